// File: rtl/counter_readout.sv
// Snapshot-and-stream readout for a bank of 64-bit event counters.
// One coherent capture per request, returned as lo/hi 32-bit words.
module counter_readout #(
   parameter int unsigned NUM_CNT = 8,
   parameter int unsigned IDX_W   = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [64*NUM_CNT-1:0]    cnt_in,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_dump,
   input  logic [IDX_W-1:0]         req_idx,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [31:0]              rsp_data,
   output logic                     rsp_last,
   output logic                     busy
);

   localparam int unsigned CNT_W  = 64;
   localparam int unsigned WORD_W = 32;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_LO = 2'd1,
      SEND_HI = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 dump_q, dump_d;
   logic [WORD_W-1:0]    data_q, data_d;
   logic                 last_q, last_d;
   logic [CNT_W-1:0]     snap_q [NUM_CNT];
   logic [CNT_W-1:0]     sel_cnt;
   logic                 accept;

   assign accept    = req_valid && (state_q == IDLE);
   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q != IDLE);
   assign rsp_data  = data_q;
   assign rsp_last  = last_q;

   // Next state plus the word that will be presented in the next cycle
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dump_d  = dump_q;
      data_d  = '0;
      last_d  = 1'b0;
      sel_cnt = '0;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = SEND_LO;
               dump_d  = req_dump;
               idx_d   = req_dump ? '0 : req_idx;
            end
         end
         SEND_LO: begin
            if (rsp_ready) state_d = SEND_HI;
         end
         SEND_HI: begin
            if (rsp_ready) begin
               if (!dump_q || (idx_q == LAST_IDX)) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = SEND_LO;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // On the accept edge the snapshot is still being written, so read the live bus
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
         if (idx_d == IDX_W'(i)) sel_cnt = accept ? cnt_in[CNT_W*i +: CNT_W] : snap_q[i];
      end

      if (state_d == SEND_LO) begin
         data_d = sel_cnt[WORD_W-1:0];
      end else if (state_d == SEND_HI) begin
         data_d = sel_cnt[CNT_W-1:WORD_W];
         last_d = !dump_d || (idx_d == LAST_IDX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         dump_q  <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dump_q  <= dump_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   // Snapshot only moves on the accept edge
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_CNT; i++) snap_q[i] <= '0;
      end else if (accept) begin
         for (int unsigned i = 0; i < NUM_CNT; i++) snap_q[i] <= cnt_in[CNT_W*i +: CNT_W];
      end
   end

endmodule

// File: tb/tb_counter_readout.sv
// Directed bench for counter_readout: counter model feeds a word scoreboard.
module tb_counter_readout;

   localparam int unsigned N8 = 8;
   localparam int unsigned N6 = 6;
   localparam int unsigned IW = 3;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [63:0]        cnt      [N8];
   logic [63:0]        load_val [N8];
   logic               load_en, inc_en;
   logic [64*N8-1:0]   cnt_flat;

   always @(posedge clk) begin
      for (int i = 0; i < int'(N8); i++) begin
         if (load_en)     cnt[i] <= load_val[i];
         else if (inc_en) cnt[i] <= cnt[i] + 64'd1;
      end
   end

   always_comb begin
      for (int i = 0; i < int'(N8); i++) cnt_flat[64*i +: 64] = cnt[i];
   end

   logic          rv8, rr8, rd8, sv8, sr8, sl8, b8;
   logic [IW-1:0] ri8;
   logic [31:0]   sd8;
   logic          rv6, rr6, rd6, sv6, sr6, sl6, b6;
   logic [IW-1:0] ri6;
   logic [31:0]   sd6;

   counter_readout #(.NUM_CNT(N8), .IDX_W(IW)) u_dut8 (
      .clk(clk), .rst(rst), .cnt_in(cnt_flat),
      .req_valid(rv8), .req_ready(rr8), .req_dump(rd8), .req_idx(ri8),
      .rsp_valid(sv8), .rsp_ready(sr8), .rsp_data(sd8), .rsp_last(sl8), .busy(b8)
   );

   counter_readout #(.NUM_CNT(N6), .IDX_W(IW)) u_dut6 (
      .clk(clk), .rst(rst), .cnt_in(cnt_flat[64*N6-1:0]),
      .req_valid(rv6), .req_ready(rr6), .req_dump(rd6), .req_idx(ri6),
      .rsp_valid(sv6), .rsp_ready(sr6), .rsp_data(sd6), .rsp_last(sl6), .busy(b6)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic o_valid(input logic s6); return s6 ? sv6 : sv8; endfunction
   function automatic logic o_last (input logic s6); return s6 ? sl6 : sl8; endfunction
   function automatic logic o_rdy  (input logic s6); return s6 ? rr6 : rr8; endfunction
   function automatic logic o_busy (input logic s6); return s6 ? b6  : b8;  endfunction
   function automatic logic [31:0] o_data(input logic s6); return s6 ? sd6 : sd8; endfunction

   task automatic set_ready(input logic s6, input logic r);
      if (s6) sr6 = r; else sr8 = r;
   endtask

   // Drive one request for a single cycle; expected words come from the pre-edge counter model
   task automatic start_req(input logic s6, input logic dump, input logic [IW-1:0] idx);
      int unsigned n;
      n = s6 ? N6 : N8;
      chk("req_ready_before", 64'(o_rdy(s6)), 64'd1);
      if (s6) begin rv6 = 1'b1; rd6 = dump; ri6 = idx; end
      else    begin rv8 = 1'b1; rd8 = dump; ri8 = idx; end
      if (dump) begin
         for (int unsigned i = 0; i < n; i++) begin
            q.push_back('{data: cnt[i][31:0],  last: 1'b0});
            q.push_back('{data: cnt[i][63:32], last: (i == n - 1)});
         end
      end else if (32'(idx) < n) begin
         q.push_back('{data: cnt[idx][31:0],  last: 1'b0});
         q.push_back('{data: cnt[idx][63:32], last: 1'b1});
      end else begin
         q.push_back('{data: 32'h0, last: 1'b0});
         q.push_back('{data: 32'h0, last: 1'b1});
      end
      @(negedge clk);
      if (s6) rv6 = 1'b0; else rv8 = 1'b0;
   endtask

   task automatic drain(input logic s6, input logic rand_rdy, input int budget);
      int   cyc;
      logic r;
      exp_t e;
      cyc = 0;
      while (q.size() != 0 && cyc < budget) begin
         r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         set_ready(s6, r);
         if (!rand_rdy) chk("stream_valid", 64'(o_valid(s6)), 64'd1);
         if (o_valid(s6) && r) begin
            e = q.pop_front();
            chk("rsp_data", 64'(o_data(s6)), 64'(e.data));
            chk("rsp_last", 64'(o_last(s6)), 64'(e.last));
         end
         @(negedge clk);
         cyc++;
      end
      chk("drain_done", 64'(q.size()), 64'd0);
      q.delete();
      set_ready(s6, 1'b1);
   endtask

   task automatic chk_idle(input logic s6, input string tag);
      chk({tag, "_req_ready"}, 64'(o_rdy(s6)),   64'd1);
      chk({tag, "_rsp_valid"}, 64'(o_valid(s6)), 64'd0);
      chk({tag, "_busy"},      64'(o_busy(s6)),  64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      rst = 1'b1; load_en = 1'b1; inc_en = 1'b0;
      for (int i = 0; i < int'(N8); i++) load_val[i] = 64'h0;
      rv8 = 1'b0; rd8 = 1'b0; ri8 = '0; sr8 = 1'b0;
      rv6 = 1'b0; rd6 = 1'b0; ri6 = '0; sr6 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0; load_en = 1'b0;
      @(negedge clk);

      // Reset state
      chk_idle(1'b0, "reset");
      chk("reset_rsp_data", 64'(sd8), 64'd0);
      chk("reset_rsp_last", 64'(sl8), 64'd0);

      // Single read of counter 3
      load_val[3] = 64'h0000_0012_3456_789A; load_en = 1'b1;
      @(negedge clk); load_en = 1'b0;
      start_req(1'b0, 1'b0, 3'd3);
      drain(1'b0, 1'b0, 10);
      chk_idle(1'b0, "single");

      // Carry on the accept edge: pre-edge value in both halves, then the carried value
      load_val[0] = 64'h0000_0000_FFFF_FFFF; load_en = 1'b1;
      @(negedge clk); load_en = 1'b0; inc_en = 1'b1;
      start_req(1'b0, 1'b0, 3'd0);
      inc_en = 1'b0;
      drain(1'b0, 1'b0, 10);
      chk_idle(1'b0, "carry1");
      start_req(1'b0, 1'b0, 3'd0);
      drain(1'b0, 1'b0, 10);
      chk_idle(1'b0, "carry2");

      // Dump with every counter running and random backpressure
      for (int i = 0; i < int'(N8); i++) load_val[i] = 64'(i) * 64'h1_0000_0001;
      load_en = 1'b1;
      @(negedge clk); load_en = 1'b0; inc_en = 1'b1;
      start_req(1'b0, 1'b1, 3'd0);
      drain(1'b0, 1'b1, 300);
      inc_en = 1'b0;
      chk_idle(1'b0, "dump");

      // Backpressure on the lo word with a competing request held high
      load_val[5] = 64'hCAFE_F00D_1234_5678; load_en = 1'b1;
      @(negedge clk); load_en = 1'b0;
      sr8 = 1'b0;
      start_req(1'b0, 1'b0, 3'd5);
      for (int k = 0; k < 5; k++) begin
         sr8 = 1'b0; rv8 = 1'b1; rd8 = 1'b0; ri8 = 3'd2;
         chk("bp_valid", 64'(sv8), 64'd1);
         chk("bp_data",  64'(sd8), 64'(q[0].data));
         chk("bp_last",  64'(sl8), 64'd0);
         chk("bp_req_ready", 64'(rr8), 64'd0);
         @(negedge clk);
      end
      rv8 = 1'b0;
      drain(1'b0, 1'b0, 10);
      chk_idle(1'b0, "bp_end");
      @(negedge clk);
      chk("bp_not_queued", 64'(sv8), 64'd0);

      // Out-of-range single read on the 6-counter instance
      sr6 = 1'b1;
      start_req(1'b1, 1'b0, 3'd7);
      drain(1'b1, 1'b0, 10);
      chk_idle(1'b1, "oor");

      // Reset after the fifth dump word
      sr8 = 1'b1;
      start_req(1'b0, 1'b1, 3'd0);
      for (int k = 1; k <= 5; k++) begin
         chk("rd_valid", 64'(sv8), 64'd1);
         e = q.pop_front();
         chk("rd_data", 64'(sd8), 64'(e.data));
         chk("rd_last", 64'(sl8), 64'(e.last));
         if (k == 5) rst = 1'b1;
         @(negedge clk);
      end
      chk("rd_abort_valid", 64'(sv8), 64'd0);
      rst = 1'b0;
      q.delete();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rd_no_more_words", 64'(sv8), 64'd0);
      end
      chk_idle(1'b0, "rd_after");
      start_req(1'b0, 1'b0, 3'd3);
      drain(1'b0, 1'b0, 10);
      chk_idle(1'b0, "rd_fresh");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_readout.md
# counter_readout

Read-side companion to the design's 64-bit event counters: it accepts a host read request, takes a coherent snapshot of all `NUM_CNT` counters on the request-accept edge, and returns the requested values as a stream of 32-bit words with valid/ready flow control. It sits between the bank of free-running 64-bit counters and the 32-bit status/debug read path. Its job is to guarantee that the upper and lower halves of any counter, and all counters within one dump, come from the same clock edge.

## Interface

- `NUM_CNT`, default 8: number of 64-bit counters attached (1..256).
- `IDX_W`, default 3: width of the counter index; must be ≥ clog2(`NUM_CNT`) and ≥1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cnt_in`  in  64*`NUM_CNT`  live counter values; counter i at bits [64i+63:64i].
- `req_valid`  in  1  host request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_dump`  in  1  1 = dump all counters; 0 = read the single counter `req_idx`.
- `req_idx`  in  `IDX_W`  counter index for a single read; ignored when `req_dump`=1.
- `rsp_valid`  out  1  `rsp_data` holds a word.
- `rsp_ready`  in  1  host accepts the word.
- `rsp_data`  out  32  response word.
- `rsp_last`  out  1  marks the final word of the response.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation

- States are IDLE, SEND_LO and SEND_HI.
- **Request accept:** a request is accepted when `req_valid` && `req_ready`.
  - On the accept edge the full `cnt_in` vector is registered into a snapshot array (64*`NUM_CNT` flops).
  - The current index is loaded with `req_idx` for a single read, or with 0 for a dump.
  - The state goes to SEND_LO.
- **SEND_LO:** `rsp_data` = snapshot[idx][31:0]. On handshake the state goes to SEND_HI.
- **SEND_HI:** `rsp_data` = snapshot[idx][63:32].
  - Handshake on a single read, or on a dump with idx = `NUM_CNT`-1: go to IDLE.
  - Handshake on any other dump word: idx increments and the state goes to SEND_LO.
- **`rsp_last`:** high only in SEND_HI of the final counter.
  - A single read always produces exactly 2 words.
  - A dump always produces 2*`NUM_CNT` words, ordered lo0, hi0, lo1, hi1, …
- **Out-of-range single read** (`req_idx` ≥ `NUM_CNT`): the block still returns 2 words, both 32'h0000_0000, and `rsp_last` is set on the second.
- **Snapshot isolation:** the snapshot is never updated outside the accept edge. Live counter activity, including carry from lower to upper half, has no effect on a response in flight.
- **Carry coherence:** if a counter carries (32'hFFFF_FFFF → upper+1) on the accept edge, the snapshot holds the pre-edge value in both halves. Mixed halves are never returned.
- **Backpressure:** while `rsp_valid`=1 and `rsp_ready`=0, `rsp_data`, `rsp_last` and the state hold unchanged.
- **Held request:** `req_valid` asserted while busy is ignored and is not queued. The host holds it until `req_ready`=1.
- **Reset:**
  - Reset at any time returns the block to IDLE. A response in progress is abandoned and no further words are emitted.
  - The snapshot array is cleared to 0.

## Timing

- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_last`=0, `busy`=0.
- `req_ready` = (state == IDLE); it is combinational from registered state only and has no dependence on `req_valid`.
- Outputs `rsp_valid`, `rsp_data` and `rsp_last` are registered or decoded from registered state; there is no combinational path from `rsp_ready` to any output.
- Accept on edge T: `rsp_valid`=1 with the lo word in cycle T+1, so first-word latency is 1 cycle.
- Words stream back-to-back with no bubble when `rsp_ready` is held high. Single read: words in cycles T+1 and T+2. Dump: 2*`NUM_CNT` consecutive cycles.
- After the final handshake at edge E, `rsp_valid`=0 and `req_ready`=1 in cycle E+1. A new request is accepted at the earliest on edge E+1.
- A response-to-request turnaround therefore costs 1 idle cycle.

## Test plan

- **Reset and single read:** after reset check `req_ready`=1 and `rsp_valid`=0. Set counter 3 to 64'h0000_0012_3456_789A and read `req_idx`=3 with `rsp_ready`=1. Require 32'h3456_789A, then 32'h0000_0012 with `rsp_last`=1 in consecutive cycles, then `req_ready`=1.
- **Carry coherence:** counter 0 = 64'h0000_0000_FFFF_FFFF and increments on the accept edge. Require 32'hFFFF_FFFF, 32'h0000_0000, never 32'h0000_0001 as the upper word. The next read returns 32'h0000_0000, 32'h0000_0001.
- **Dump with live counters:** `NUM_CNT`=8, counter i = i*64'h1_0000_0001, all incrementing every cycle, random `rsp_ready`. Require 16 words matching the values at the accept edge, with `rsp_last` only on word 16.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles on the lo word. Require `rsp_data`, `rsp_valid`=1 and `rsp_last`=0 stable, and a request asserted meanwhile is not accepted (`req_ready`=0).
- **Out of range:** `NUM_CNT`=6, `req_idx`=7. Require 32'h0, then 32'h0 with `rsp_last`=1.
- **Reset mid-dump:** assert `rst` after word 5 of a dump. Require `rsp_valid`=0 on the next cycle and no further words, then `req_ready`=1 and a fresh single read completing correctly.
